// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_prog_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam int          CLKS_PER_BIT_DEF = 347;
    localparam int          ADDR_W_DEF       = 14;
    localparam logic [31:0] END_WORD_DEF     = 32'h0000_0FFF;

    // Bit-timing counter width; it must hold CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks);
        return $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling FSM.
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int             CNT_W     = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_s;
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign byte_data = shreg;

    // Bring the asynchronous line into the clock domain; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: half-bit to centre on the start bit, then one bit period per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx_s) state <= START;
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            // A start bit that is gone by mid-bit was a glitch.
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[7:1]};
                            if (bit_idx == 3'd7) state <= STOP;
                            else bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (rx_s) byte_valid <= 1'b1;
                            else      frame_err  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: packs received bytes little-endian into words and
// writes them to instruction memory until the terminator word arrives.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int          ADDR_W       = ADDR_W_DEF,
    parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable_i,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              prog_done_o,
    output logic              core_rst_o,
    output logic              frame_err_o,
    output logic              addr_ovf_o
);
    logic        rx_en;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ferr;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic        word_rdy;

    // Once the program is in, the line is ignored until reset.
    assign rx_en      = enable_i & ~prog_done_o;
    assign core_rst_o = ~prog_done_o;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .en         (rx_en),
        .rx         (rx_i),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_ferr)
    );

    // Byte packing, word dispatch, address counter and sticky status.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_idx    <= '0;
            word        <= '0;
            word_rdy    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            prog_done_o <= 1'b0;
            frame_err_o <= 1'b0;
            addr_ovf_o  <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            word_rdy <= 1'b0;

            // Address advances the cycle after each strobe.
            if (mem_we_o) begin
                mem_addr_o <= mem_addr_o + ADDR_W'(1);
                if (&mem_addr_o) addr_ovf_o <= 1'b1;
            end

            if (rx_ferr) frame_err_o <= 1'b1;

            if (!enable_i) begin
                byte_idx <= '0;
                word     <= '0;
            end else if (rx_valid) begin
                word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) word_rdy <= 1'b1;
            end

            // The terminator closes loading and is never written.
            if (word_rdy) begin
                if (word == END_WORD) begin
                    prog_done_o <= 1'b1;
                end else begin
                    mem_we_o    <= 1'b1;
                    mem_wdata_o <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table vectors, corner sequences, random traffic
// against a byte-queue model of the loader.
module tb_uart_prog_loader;
    localparam int          CPB      = 16;
    localparam logic [31:0] END_WORD = 32'h0000_0FFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic rx  = 1'b1;

    logic        we_a, done_a, crst_a, ferr_a, ovf_a;
    logic [13:0] addr_a;
    logic [31:0] wdata_a;
    logic        we_b, done_b, crst_b, ferr_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(14), .END_WORD(END_WORD)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en), .rx_i(rx),
        .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .prog_done_o(done_a), .core_rst_o(crst_a), .frame_err_o(ferr_a), .addr_ovf_o(ovf_a));

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .END_WORD(END_WORD)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en), .rx_i(rx),
        .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .prog_done_o(done_b), .core_rst_o(crst_b), .frame_err_o(ferr_b), .addr_ovf_o(ovf_b));

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        bit          exp_write;
        logic [13:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    wr_t        act_q[$];
    wr_t        exp_q[$];
    logic [1:0] act_b_q[$];

    // reference model state
    logic [7:0] m_bytes[$];
    int         m_addr;
    bit         m_done, m_ferr, m_ovf;

    // capture every strobed write; a stretched strobe shows up as extra entries
    always @(negedge clk) begin
        if (we_a) act_q.push_back({addr_a, wdata_a});
        if (we_b) act_b_q.push_back(addr_b);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        cyc(3);
        rst = 1'b0;
        act_q.delete();
        exp_q.delete();
        act_b_q.delete();
        m_bytes.delete();
        m_addr = 0;
        m_done = 0;
        m_ferr = 0;
        m_ovf  = 0;
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        en = v;
        if (!v) m_bytes.delete();
    endtask

    // Drive one 8N1 frame; a bad frame holds stop low past its centre, then idles.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [31:0] w;
        @(negedge clk);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        if (stop_ok) begin
            rx = 1'b1;
            cyc(CPB);
        end else begin
            rx = 1'b0;
            cyc(CPB * 3 / 4);
            rx = 1'b1;
            cyc(CPB / 4 + CPB);
        end
        if (en && !m_done) begin
            if (!stop_ok) begin
                m_ferr = 1;
            end else begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_bytes.delete();
                    if (w == END_WORD) begin
                        m_done = 1;
                    end else begin
                        exp_q.push_back({14'(m_addr), w});
                        if (m_addr == 16383) m_ovf = 1;
                        m_addr = (m_addr + 1) % 16384;
                    end
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    // Compare captured writes and sticky flags of dut_a with the model.
    task automatic compare_model(input string tag);
        int n;
        cyc(2 * CPB);
        check({tag, " nwrites"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " waddr"}, 32'(act_q[i].addr), 32'(exp_q[i].addr));
            check({tag, " wdata"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
        check({tag, " prog_done"}, 32'(done_a), 32'(m_done));
        check({tag, " core_rst"},  32'(crst_a), 32'(!m_done));
        check({tag, " frame_err"}, 32'(ferr_a), 32'(m_ferr));
        check({tag, " addr_ovf"},  32'(ovf_a),  32'(m_ovf));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_0513, 1'b1, 14'd0, 32'h0000_0513};
        vecs[1] = '{32'hDEAD_BEEF, 1'b1, 14'd1, 32'hDEAD_BEEF};
        vecs[2] = '{32'h0000_0000, 1'b1, 14'd2, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 14'd3, 32'hFFFF_FFFF};
        vecs[4] = '{32'hA5A5_5A5A, 1'b1, 14'd4, 32'hA5A5_5A5A};
        vecs[5] = '{32'h0000_0FFE, 1'b1, 14'd5, 32'h0000_0FFE};
        vecs[6] = '{32'hFFFF_0FFF, 1'b1, 14'd6, 32'hFFFF_0FFF};
        vecs[7] = '{32'h1234_5678, 1'b1, 14'd7, 32'h1234_5678};
        vecs[8] = '{32'h0000_0FFF, 1'b0, 14'd0, 32'h0000_0000};
        vecs[9] = '{32'h0BAD_F00D, 1'b0, 14'd0, 32'h0000_0000};

        // reset state
        do_reset();
        cyc(2);
        check("rst we",        32'(we_a),   32'd0);
        check("rst addr",      32'(addr_a), 32'd0);
        check("rst wdata",     wdata_a,     32'd0);
        check("rst prog_done", 32'(done_a), 32'd0);
        check("rst core_rst",  32'(crst_a), 32'd1);
        check("rst frame_err", 32'(ferr_a), 32'd0);
        check("rst addr_ovf",  32'(ovf_a),  32'd0);

        // table: 8 words, terminator, then traffic that must be ignored
        for (int i = 0; i < 10; i++) begin
            send_word(vecs[i].word);
            cyc(2 * CPB);
            check("vec nwrites", act_q.size(), vecs[i].exp_write ? 32'd1 : 32'd0);
            if (vecs[i].exp_write && act_q.size() > 0) begin
                check("vec addr", 32'(act_q[0].addr), 32'(vecs[i].exp_addr));
                check("vec data", act_q[0].data, vecs[i].exp_data);
            end
            act_q.delete();
            exp_q.delete();
        end
        compare_model("after_end");

        // bad stop bit, then 4 good bytes
        do_reset();
        send_byte(8'h77, 1'b0);
        send_word(32'h4433_2211);
        compare_model("frame_err");

        // short low glitch must not start a frame
        do_reset();
        @(negedge clk);
        rx = 1'b0;
        cyc(CPB / 4);
        rx = 1'b1;
        cyc(3 * CPB);
        check("glitch frame_err", 32'(ferr_a), 32'd0);
        check("glitch nwrites", act_q.size(), 32'd0);
        send_word(32'hCAFE_0001);
        compare_model("post_glitch");

        // enable dropped after 2 bytes discards the partial word
        do_reset();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        set_en(1'b0);
        cyc(CPB);
        set_en(1'b1);
        send_word(32'h0403_0201);
        compare_model("enable_drop");

        // reset mid-word loses the partial bytes
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        do_reset();
        send_word(32'h8877_6655);
        compare_model("rst_midword");

        // 2-bit address space wraps after the fourth write
        do_reset();
        for (int w = 0; w < 5; w++) begin
            send_word($urandom());
            if (w == 2) begin
                cyc(2 * CPB);
                check("wrap ovf early", 32'(ovf_b), 32'd0);
            end
        end
        cyc(2 * CPB);
        check("wrap nwrites", act_b_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < act_b_q.size(); i++)
            check("wrap addr", 32'(act_b_q[i]), 32'(i % 4));
        check("wrap ovf", 32'(ovf_b), 32'd1);
        compare_model("wrap_a");

        // random traffic with occasional bad frames and enable drops
        do_reset();
        for (int w = 0; w < 10; w++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(7) == 0) send_byte(8'($urandom()), 1'b0);
                if (k > 0 && $urandom_range(9) == 0) begin
                    set_en(1'b0);
                    cyc($urandom_range(CPB, 1));
                    set_en(1'b1);
                end
                send_byte(8'($urandom()), 1'b1);
            end
        end
        compare_model("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
